// File: rtl/vptimer_pkg.sv
// Shared definitions for the multi-channel VP1-014 style timer: register map,
// CONTROL bit positions, prescaler tock selection and read-word formatting.
package vptimer_pkg;

  localparam logic [1:0] REG_RELOAD  = 2'd0;
  localparam logic [1:0] REG_COUNTER = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_W     = 9;
  localparam int CB_STOP    = 0;
  localparam int CB_WRAP    = 1;
  localparam int CB_EXPEN   = 2;
  localparam int CB_ONESHOT = 3;
  localparam int CB_RUN     = 4;
  localparam int CB_DIV16   = 5;
  localparam int CB_DIV4    = 6;
  localparam int CB_EXPIRY  = 7;
  localparam int CB_IRQEN   = 8;

  // Encoding is {DIV4, DIV16}
  typedef enum logic [1:0] {
    TOCK_EVERY = 2'b00,
    TOCK_PRE16 = 2'b01,
    TOCK_PRE4  = 2'b10,
    TOCK_PRE64 = 2'b11
  } tock_sel_e;

  function automatic logic tock_hit(input tock_sel_e sel, input logic [5:0] pre);
    logic hit;
    case (sel)
      TOCK_EVERY: hit = 1'b1;
      TOCK_PRE16: hit = (pre[3:0] == 4'd0);
      TOCK_PRE4:  hit = (pre[1:0] == 2'd0);
      TOCK_PRE64: hit = (pre == 6'd0);
      default:    hit = 1'b1;
    endcase
    return hit;
  endfunction

  function automatic logic [15:0] reg_word(input logic [1:0] rg, input logic [15:0] reload,
                                           input logic [15:0] counter, input logic [CTRL_W-1:0] ctrl);
    logic [15:0] word;
    case (rg)
      REG_RELOAD:  word = reload;
      REG_COUNTER: word = counter;
      REG_CONTROL: word = {7'h7f, ctrl};
      REG_STATUS:  word = {15'h0000, ctrl[CB_EXPIRY]};
      default:     word = 16'hffff;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/vptimer_chan.sv
// One timer channel: reload, down-counter, control word and sticky expiry.
module vptimer_chan
  import vptimer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DW    = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_tick,
  input  logic [5:0]        i_pre,
  input  logic              i_wr_reload,
  input  logic              i_wr_ctrl,
  input  logic              i_wr_status,
  input  logic [DW-1:0]     i_data,
  output logic [CNT_W-1:0]  o_reload,
  output logic [CNT_W-1:0]  o_counter,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_irq_req
);

  logic [CNT_W-1:0]  r_reload;
  logic [CNT_W-1:0]  r_counter;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  w_counter_nxt;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic              w_running;
  logic              w_step;
  logic              w_expire;

  assign w_running = r_ctrl[CB_RUN] & ~r_ctrl[CB_STOP];
  assign w_step    = w_running & i_tick
                   & tock_hit(tock_sel_e'({r_ctrl[CB_DIV4], r_ctrl[CB_DIV16]}), i_pre);
  assign w_expire  = w_step & (r_counter == {CNT_W{1'b0}}) & ~r_ctrl[CB_WRAP];

  // Next counter/control; a bus write beats the tick, and W1C beats a new expiry
  always_comb begin
    w_counter_nxt = r_counter;
    w_ctrl_nxt    = r_ctrl;
    if (i_wr_ctrl) begin
      w_ctrl_nxt = i_data[CTRL_W-1:0];
      if (i_data[CB_RUN]) begin
        w_counter_nxt = r_reload;
      end else begin
        w_counter_nxt = r_counter;
      end
    end else if (!w_running) begin
      w_counter_nxt = r_reload;
    end else if (w_expire) begin
      w_counter_nxt          = (r_reload == {CNT_W{1'b0}}) ? {CNT_W{1'b1}} : r_reload;
      w_ctrl_nxt[CB_RUN]     = ~r_ctrl[CB_ONESHOT];
      w_ctrl_nxt[CB_EXPIRY]  = r_ctrl[CB_EXPIRY] | r_ctrl[CB_EXPEN];
    end else if (w_step) begin
      w_counter_nxt = r_counter - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_counter_nxt = r_counter;
    end
    if (i_wr_status && i_data[0]) begin
      w_ctrl_nxt[CB_EXPIRY] = 1'b0;
    end else begin
      w_ctrl_nxt[CB_EXPIRY] = w_ctrl_nxt[CB_EXPIRY];
    end
  end

  // Channel state registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_reload  <= {CNT_W{1'b0}};
      r_counter <= {CNT_W{1'b0}};
      r_ctrl    <= {CTRL_W{1'b0}};
    end else begin
      if (i_wr_reload) begin
        r_reload <= i_data[CNT_W-1:0];
      end
      r_counter <= w_counter_nxt;
      r_ctrl    <= w_ctrl_nxt;
    end
  end

  assign o_reload  = r_reload;
  assign o_counter = r_counter;
  assign o_ctrl    = r_ctrl;
  assign o_irq_req = r_ctrl[CB_EXPIRY] & r_ctrl[CB_IRQEN];

endmodule

// File: rtl/vptimer_multi.sv
// Multi-channel timer top: bus decode, shared tick divider and prescaler,
// registered read mux and combined interrupt.
module vptimer_multi
  import vptimer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 1067,
  parameter int PRE_W    = 6,
  localparam int AW      = 2 + $clog2(N_CH)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_regwr,
  input  logic          i_regrd,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_data,
  output logic [15:0]   o_data,
  output logic          o_irq
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW    = (CNT_W > CTRL_W) ? CNT_W : CTRL_W;

  logic [DIV_W-1:0]  r_div;
  logic [PRE_W-1:0]  r_pre;
  logic [15:0]       r_data;
  logic              r_irq;
  logic              w_tick;
  logic [CH_W-1:0]   w_ch;
  logic              w_ch_ok;
  logic              w_wr;
  logic              w_rd;
  logic [15:0]       w_rd_data;
  logic [15:0]       w_chan_word [N_CH];
  logic [N_CH-1:0]   w_sel;
  logic [N_CH-1:0]   w_irq_req;
  logic [CNT_W-1:0]  w_reload  [N_CH];
  logic [CNT_W-1:0]  w_counter [N_CH];
  logic [CTRL_W-1:0] w_ctrl    [N_CH];

  if (AW > 2) begin : g_ch_field
    assign w_ch = i_addr[AW-1:2];
  end else begin : g_ch_zero
    assign w_ch = {CH_W{1'b0}};
  end

  assign w_ch_ok = (int'(w_ch) < N_CH);
  assign w_wr    = i_ce & i_regwr;
  assign w_rd    = i_ce & i_regrd & ~i_regwr;
  assign w_tick  = (r_div == {DIV_W{1'b0}});

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    assign w_sel[g] = w_ch_ok & (w_ch == CH_W'(g));

    vptimer_chan #(.CNT_W(CNT_W), .DW(DW)) u_chan (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_tick      (w_tick),
      .i_pre       (r_pre[5:0]),
      .i_wr_reload (w_wr & w_sel[g] & (i_addr[1:0] == REG_RELOAD)),
      .i_wr_ctrl   (w_wr & w_sel[g] & (i_addr[1:0] == REG_CONTROL)),
      .i_wr_status (w_wr & w_sel[g] & (i_addr[1:0] == REG_STATUS)),
      .i_data      (i_data[DW-1:0]),
      .o_reload    (w_reload[g]),
      .o_counter   (w_counter[g]),
      .o_ctrl      (w_ctrl[g]),
      .o_irq_req   (w_irq_req[g])
    );

    assign w_chan_word[g] = reg_word(i_addr[1:0], 16'(w_reload[g]), 16'(w_counter[g]), w_ctrl[g]);
  end

  // Read mux: at most one channel is selected, so an OR of gated words is enough
  always_comb begin
    w_rd_data = 16'h0000;
    for (int c = 0; c < N_CH; c++) begin
      w_rd_data = w_rd_data | (w_sel[c] ? w_chan_word[c] : 16'h0000);
    end
    if (!w_ch_ok) begin
      w_rd_data = 16'hffff;
    end else begin
      w_rd_data = w_rd_data;
    end
  end

  // Base tick divider and shared prescaler
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_div <= {DIV_W{1'b0}};
      r_pre <= {PRE_W{1'b0}};
    end else if (w_tick) begin
      r_div <= DIV_W'(TICK_DIV - 1);
      r_pre <= r_pre + {{(PRE_W-1){1'b0}}, 1'b1};
    end else begin
      r_div <= r_div - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered read data and interrupt
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_data <= 16'h0000;
      r_irq  <= 1'b0;
    end else begin
      if (w_rd) begin
        r_data <= w_rd_data;
      end
      r_irq <= |w_irq_req;
    end
  end

  assign o_data = r_data;
  assign o_irq  = r_irq;

endmodule

// File: tb/tb_vptimer_multi.sv
// Scenario bench for vptimer_multi with a short tick period; expected read
// words are queued when a read is issued and compared when data_o returns.
module tb_vptimer_multi;

  localparam int N_CH = 5;
  localparam int TD   = 8;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b0;
  logic          regwr = 1'b0;
  logic          regrd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [15:0]   wdata = 16'h0000;
  logic [15:0]   rdata;
  logic          irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_k = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got;
  logic [15:0] exp_v;

  vptimer_multi #(.N_CH(N_CH), .CNT_W(16), .TICK_DIV(TD), .PRE_W(6)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_ce(ce), .i_regwr(regwr), .i_regrd(regrd),
    .i_addr(addr), .i_data(wdata), .o_data(rdata), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Index of the next rising edge since reset release; ticks land where edge_k % TD == 0
  always @(posedge clk) begin
    if (!reset_n) edge_k <= 0;
    else          edge_k <= edge_k + 1;
  end

  task automatic goto(input int k);
    if (edge_k > k) begin
      n_cmp++; n_bad++;
      $display("FAIL schedule edge %0d required %0d", edge_k, k);
    end
    while (edge_k < k) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wr(input int ch, input int rg, input logic [15:0] d);
    ce = 1'b1; regwr = 1'b1; addr = AW'(ch * 4 + rg); wdata = d;
    @(negedge clk);
    ce = 1'b0; regwr = 1'b0;
  endtask

  task automatic rd(input int ch, input int rg, output logic [15:0] d);
    ce = 1'b1; regrd = 1'b1; addr = AW'(ch * 4 + rg);
    @(negedge clk);
    ce = 1'b0; regrd = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [15:0] e[4] = '{16'h0000, 16'h0000, 16'hfe00, 16'h0000};
    do_reset();
    n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_data0 got %h want 0000", rdata); end
    goto(2); wr(0, 0, 16'h0001); wr(0, 2, 16'h0114);
    goto(20);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rst_pre_irq got %b want 1", irq); end
    exp_q.push_back(16'h0001); rd(0, 0, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL rst_pre_reload got %h want %h", got, exp_v); end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_data got %h want 0000", rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b want 0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(e[r]); rd(0, r, got); exp_v = exp_q.pop_front();
      n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL rst_reg%0d got %h want %h", r, got, exp_v); end
    end
  endtask

  task automatic test_periodic();
    logic [15:0] e[5] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
    do_reset();
    goto(2); wr(0, 0, 16'h0003); wr(0, 2, 16'h0014);
    for (int i = 0; i < 5; i++) begin
      goto(4 + TD * i);
      exp_q.push_back(e[i]); rd(0, 1, got); exp_v = exp_q.pop_front();
      n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL per_cnt%0d got %h want %h", i, got, exp_v); end
    end
    exp_q.push_back(16'h0001); exp_q.push_back(16'hfe94);
    rd(0, 3, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL per_status got %h want %h", got, exp_v); end
    rd(0, 2, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL per_ctrl got %h want %h", got, exp_v); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL per_irq got %b want 0", irq); end
    goto(44);
    exp_q.push_back(16'd2); rd(0, 1, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL per_rerun got %h want %h", got, exp_v); end
  endtask

  task automatic test_oneshot_irq();
    do_reset();
    goto(2); wr(1, 0, 16'h0002); wr(1, 2, 16'h011c);
    goto(20);
    exp_q.push_back(16'd0); rd(1, 1, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL os_cnt got %h want %h", got, exp_v); end
    goto(25);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL os_irq_early got %b want 0", irq); end
    goto(26);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL os_irq got %b want 1", irq); end
    exp_q.push_back(16'hff8c); exp_q.push_back(16'd2);
    rd(1, 2, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL os_ctrl got %h want %h", got, exp_v); end
    rd(1, 1, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL os_track got %h want %h", got, exp_v); end
    wr(1, 3, 16'h0000);
    exp_q.push_back(16'h0001); rd(1, 3, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL os_w0 got %h want %h", got, exp_v); end
    wr(1, 3, 16'h0001);
    goto(32);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL os_irq_clr got %b want 0", irq); end
    exp_q.push_back(16'h0000); rd(1, 3, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL os_w1c got %h want %h", got, exp_v); end
  endtask

  task automatic test_wrap();
    logic [15:0] e[3] = '{16'h0000, 16'hffff, 16'hfffe};
    do_reset();
    goto(2); wr(2, 0, 16'h0000); wr(2, 2, 16'h0016);
    for (int i = 0; i < 3; i++) begin
      goto(4 + TD * i);
      exp_q.push_back(e[i]); rd(2, 1, got); exp_v = exp_q.pop_front();
      n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL wrap_cnt%0d got %h want %h", i, got, exp_v); end
    end
    exp_q.push_back(16'h0000); rd(2, 3, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL wrap_noexp got %h want %h", got, exp_v); end
    wr(2, 2, 16'h0014);
    goto(25);
    exp_q.push_back(16'hffff); exp_q.push_back(16'h0001);
    rd(2, 1, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL wrap_reload0 got %h want %h", got, exp_v); end
    rd(2, 3, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL wrap_exp got %h want %h", got, exp_v); end
  endtask

  task automatic test_prescale();
    int          at[5] = '{4, 124, 132, 252, 260};
    logic [15:0] e[5]  = '{16'd100, 16'd100, 16'd99, 16'd99, 16'd98};
    int          at2[3] = '{388, 508, 516};
    logic [15:0] e2[3]  = '{16'd100, 16'd100, 16'd99};
    do_reset();
    goto(2); wr(3, 0, 16'd100); wr(3, 2, 16'h0030);
    for (int i = 0; i < 5; i++) begin
      goto(at[i]);
      exp_q.push_back(e[i]); rd(3, 1, got); exp_v = exp_q.pop_front();
      n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL div16_%0d got %h want %h", i, got, exp_v); end
    end
    wr(3, 2, 16'h0070);
    for (int i = 0; i < 3; i++) begin
      goto(at2[i]);
      exp_q.push_back(e2[i]); rd(3, 1, got); exp_v = exp_q.pop_front();
      n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL div64_%0d got %h want %h", i, got, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    goto(2); wr(0, 0, 16'h0001); wr(0, 2, 16'h0014);
    goto(16); wr(0, 2, 16'h0114);
    exp_q.push_back(16'hff14); exp_q.push_back(16'h0001);
    rd(0, 2, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL b2b_ctrl got %h want %h", got, exp_v); end
    rd(0, 1, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL b2b_cnt got %h want %h", got, exp_v); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL b2b_irq got %b want 0", irq); end
    goto(32); wr(0, 3, 16'h0001);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    rd(0, 3, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL b2b_w1c got %h want %h", got, exp_v); end
    rd(0, 1, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL b2b_reload got %h want %h", got, exp_v); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL b2b_irq2 got %b want 0", irq); end
    exp_q.push_back(16'hffff); exp_q.push_back(16'hffff);
    rd(N_CH, 1, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL bad_ch got %h want %h", got, exp_v); end
    rd(7, 0, got); exp_v = exp_q.pop_front();
    n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL bad_ch7 got %h want %h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot_irq();
    test_wrap();
    test_prescale();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
